// File: rtl/l1_dp_mem_sweep_rd.sv
// Read-side sweep engine for the L1 dual-port memories: walks indices 0..DEPTH-1
// through the read port and streams {index, data} pairs through a 2-entry output FIFO.
module l1_dp_mem_sweep_rd #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 1024,
  localparam int AW = $clog2(DEPTH)
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             START,
  input  logic             MEM_READY,
  output logic             BUSY,
  output logic             DONE,
  output logic             REN,
  output logic [AW-1:0]    RADDR,
  input  logic [WIDTH-1:0] RDATA,
  output logic             OUT_VAL,
  output logic [AW-1:0]    OUT_ADDR,
  output logic [WIDTH-1:0] OUT_DATA,
  input  logic             OUT_RDY,
  output logic [1:0]       dbg_state
);

  // Output handshake: an entry transfers in any cycle where OUT_VAL and OUT_RDY are
  // both high; OUT_VAL never drops and OUT_ADDR/OUT_DATA never change until it does.
  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SWEEP = 2'd1,
    S_DRAIN = 2'd2
  } state_e;

  localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

  state_e           state_q, state_d;
  logic             start_pend_q, start_pend_d;
  logic [AW-1:0]    cnt_q, cnt_d;
  logic [AW-1:0]    raddr_q, raddr_d;
  logic             inflight_q, inflight_d;
  logic [AW-1:0]    infl_addr_q, infl_addr_d;
  logic             done_q, done_d;
  logic [AW-1:0]    fifo_addr_q [2];
  logic [AW-1:0]    fifo_addr_d [2];
  logic [WIDTH-1:0] fifo_data_q [2];
  logic [WIDTH-1:0] fifo_data_d [2];
  logic             wr_ptr_q, wr_ptr_d;
  logic             rd_ptr_q, rd_ptr_d;
  logic [1:0]       count_q, count_d;

  logic       pop;
  logic       push;
  logic       ren;
  logic       last_hs;
  logic [2:0] occ;

  always_comb begin
    pop     = (count_q != 2'd0) && OUT_RDY;
    push    = inflight_q;
    occ     = {1'b0, count_q} + {2'b00, inflight_q};
    // Occupancy after this cycle's pop must leave room for the read about to be issued.
    ren     = (state_q == S_SWEEP) && MEM_READY && (occ < (3'd2 + {2'b00, pop}));
    last_hs = pop && (fifo_addr_q[rd_ptr_q] == LAST_IDX);
  end

  always_comb begin
    state_d      = state_q;
    start_pend_d = start_pend_q;
    cnt_d        = cnt_q;
    raddr_d      = raddr_q;
    inflight_d   = ren;
    infl_addr_d  = infl_addr_q;
    done_d       = 1'b0;
    fifo_addr_d  = fifo_addr_q;
    fifo_data_d  = fifo_data_q;
    wr_ptr_d     = wr_ptr_q ^ push;
    rd_ptr_d     = rd_ptr_q ^ pop;
    count_d      = count_q + {1'b0, push} - {1'b0, pop};

    case (state_q)
      S_IDLE: begin
        if (START) start_pend_d = 1'b1;
        if ((start_pend_q || START) && MEM_READY) begin
          state_d      = S_SWEEP;
          start_pend_d = 1'b0;
          cnt_d        = '0;
        end
      end
      S_SWEEP: begin
        if (ren && (cnt_q == LAST_IDX)) state_d = S_DRAIN;
      end
      S_DRAIN: begin
        if (last_hs) begin
          state_d = S_IDLE;
          done_d  = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (ren) begin
      cnt_d       = cnt_q + 1'b1;
      raddr_d     = cnt_q;
      infl_addr_d = cnt_q;
    end

    // RDATA belongs to the read issued last cycle; tag it with that address.
    if (push) begin
      fifo_addr_d[wr_ptr_q] = infl_addr_q;
      fifo_data_d[wr_ptr_q] = RDATA;
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= S_IDLE;
      start_pend_q <= 1'b0;
      cnt_q        <= '0;
      raddr_q      <= '0;
      inflight_q   <= 1'b0;
      infl_addr_q  <= '0;
      done_q       <= 1'b0;
      fifo_addr_q  <= '{default: '0};
      fifo_data_q  <= '{default: '0};
      wr_ptr_q     <= 1'b0;
      rd_ptr_q     <= 1'b0;
      count_q      <= 2'd0;
    end else begin
      state_q      <= state_d;
      start_pend_q <= start_pend_d;
      cnt_q        <= cnt_d;
      raddr_q      <= raddr_d;
      inflight_q   <= inflight_d;
      infl_addr_q  <= infl_addr_d;
      done_q       <= done_d;
      fifo_addr_q  <= fifo_addr_d;
      fifo_data_q  <= fifo_data_d;
      wr_ptr_q     <= wr_ptr_d;
      rd_ptr_q     <= rd_ptr_d;
      count_q      <= count_d;
    end
  end

  assign BUSY      = (state_q != S_IDLE);
  assign DONE      = done_q;
  assign REN       = ren;
  assign RADDR     = ren ? cnt_q : raddr_q;
  assign OUT_VAL   = (count_q != 2'd0);
  assign OUT_ADDR  = fifo_addr_q[rd_ptr_q];
  assign OUT_DATA  = fifo_data_q[rd_ptr_q];
  assign dbg_state = state_q;

endmodule

// File: tb/tb_l1_dp_mem_sweep_rd.sv
// Directed bench for l1_dp_mem_sweep_rd with DEPTH=8 and a 1-cycle-latency memory model.
module tb_l1_dp_mem_sweep_rd;
  localparam int W  = 32;
  localparam int D  = 8;
  localparam int AW = 3;

  localparam int M_PLAIN     = 0;
  localparam int M_BP        = 1;
  localparam int M_DEFER     = 2;
  localparam int M_BUSYSTART = 3;
  localparam int M_B2B       = 4;

  logic          CLK = 1'b0;
  logic          RST, START, MEM_READY, OUT_RDY;
  logic          BUSY, DONE, REN, OUT_VAL;
  logic [AW-1:0] RADDR, OUT_ADDR;
  logic [W-1:0]  RDATA, OUT_DATA;
  logic [1:0]    dbg_state;

  l1_dp_mem_sweep_rd #(.WIDTH(W), .DEPTH(D)) dut (
    .CLK(CLK), .RST(RST), .START(START), .MEM_READY(MEM_READY),
    .BUSY(BUSY), .DONE(DONE), .REN(REN), .RADDR(RADDR), .RDATA(RDATA),
    .OUT_VAL(OUT_VAL), .OUT_ADDR(OUT_ADDR), .OUT_DATA(OUT_DATA),
    .OUT_RDY(OUT_RDY), .dbg_state(dbg_state)
  );

  // ---------------- clock / reset / memory model ----------------
  always #5 CLK = ~CLK;

  int cyc = 0;
  int t0  = 0;
  always @(posedge CLK) cyc <= cyc + 1;

  logic [W-1:0] mem [D];
  initial for (int i = 0; i < D; i++) mem[i] = 32'hA0 + i;
  always @(posedge CLK) if (REN) RDATA <= mem[RADDR];

  // ---------------- monitor (samples on negedge) ----------------
  int            ren_cyc[$];
  logic [AW-1:0] ren_addr[$];
  int            hs_cyc[$];
  logic [AW-1:0] hs_addr[$];
  logic [W-1:0]  hs_data[$];
  int            done_cyc[$];
  int            busy_cyc[$];
  int            stall_err = 0;
  logic          prev_stall = 1'b0;
  logic [AW-1:0] prev_addr;
  logic [W-1:0]  prev_data;

  always @(negedge CLK) begin
    if (RST) begin
      prev_stall = 1'b0;
    end else begin
      if (REN) begin ren_cyc.push_back(cyc - t0); ren_addr.push_back(RADDR); end
      if (OUT_VAL && OUT_RDY) begin
        hs_cyc.push_back(cyc - t0); hs_addr.push_back(OUT_ADDR); hs_data.push_back(OUT_DATA);
      end
      if (DONE) done_cyc.push_back(cyc - t0);
      if (BUSY) busy_cyc.push_back(cyc - t0);
      if (prev_stall && (!OUT_VAL || OUT_ADDR !== prev_addr || OUT_DATA !== prev_data))
        stall_err++;
      prev_stall = OUT_VAL && !OUT_RDY;
      prev_addr  = OUT_ADDR;
      prev_data  = OUT_DATA;
    end
  end

  // ---------------- scoreboard state ----------------
  logic [AW+W-1:0] exp_q[$];
  logic [AW+W-1:0] exp_e;
  int n_checks = 0;
  int n_fail   = 0;

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic clear_logs();
    ren_cyc.delete(); ren_addr.delete(); hs_cyc.delete(); hs_addr.delete();
    hs_data.delete(); done_cyc.delete(); busy_cyc.delete(); exp_q.delete();
    stall_err = 0;
  endtask

  task automatic drive_sweep(input int mode, input int budget, input int n_done);
    int c;
    int rdy_pat[4];
    rdy_pat = '{1, 0, 0, 1};
    clear_logs();
    t0 = cyc;
    c  = 0;
    while (c <= budget && done_cyc.size() < n_done) begin
      c = cyc - t0;
      START     = (c == 0) || (mode == M_BUSYSTART && c == 4) || (mode == M_B2B && c == 11);
      MEM_READY = (mode == M_DEFER) ? (c >= 5 && (c < 9 || c > 11)) : 1'b1;
      OUT_RDY   = (mode == M_BP) ? (rdy_pat[c % 4] != 0) : 1'b1;
      step();
    end
    START = 1'b0; MEM_READY = 1'b1; OUT_RDY = 1'b1;
    repeat (3) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    RST = 1'b1; START = 1'b0; MEM_READY = 1'b0; OUT_RDY = 1'b0;
    repeat (2) step();
    n_checks++; if (BUSY !== 1'b0)    begin n_fail++; $display("FAIL reset_busy got %b exp 0", BUSY); end
    n_checks++; if (DONE !== 1'b0)    begin n_fail++; $display("FAIL reset_done got %b exp 0", DONE); end
    n_checks++; if (REN !== 1'b0)     begin n_fail++; $display("FAIL reset_ren got %b exp 0", REN); end
    n_checks++; if (OUT_VAL !== 1'b0) begin n_fail++; $display("FAIL reset_out_val got %b exp 0", OUT_VAL); end
    n_checks++; if (RADDR !== '0)     begin n_fail++; $display("FAIL reset_raddr got %0d exp 0", RADDR); end
    n_checks++; if (OUT_ADDR !== '0)  begin n_fail++; $display("FAIL reset_out_addr got %0d exp 0", OUT_ADDR); end
    n_checks++; if (OUT_DATA !== '0)  begin n_fail++; $display("FAIL reset_out_data got %h exp 0", OUT_DATA); end
    RST = 1'b0;
    step();
  endtask

  task automatic test_init_sweep();
    drive_sweep(M_PLAIN, 40, 1);
    for (int i = 0; i < D; i++) exp_q.push_back({AW'(i), 32'hA0 + i});
    n_checks++; if (ren_cyc.size() != D) begin n_fail++; $display("FAIL init_ren_count got %0d exp %0d", ren_cyc.size(), D); end
    for (int i = 0; i < ren_cyc.size() && i < D; i++) begin
      n_checks++;
      if (ren_cyc[i] != i + 1 || ren_addr[i] !== AW'(i)) begin
        n_fail++; $display("FAIL init_ren[%0d] got cyc %0d addr %0d exp cyc %0d addr %0d", i, ren_cyc[i], ren_addr[i], i + 1, i);
      end
    end
    n_checks++; if (hs_cyc.size() != D) begin n_fail++; $display("FAIL init_hs_count got %0d exp %0d", hs_cyc.size(), D); end
    for (int i = 0; i < hs_cyc.size() && exp_q.size() > 0; i++) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if ({hs_addr[i], hs_data[i]} !== exp_e || hs_cyc[i] != i + 3) begin
        n_fail++; $display("FAIL init_out[%0d] got cyc %0d (%0d,%h) exp cyc %0d (%0d,%h)", i, hs_cyc[i], hs_addr[i], hs_data[i], i + 3, exp_e[W+AW-1:W], exp_e[W-1:0]);
      end
    end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 11) begin
      n_fail++; $display("FAIL init_done got %0d pulses first %0d exp 1 pulse at 11", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    n_checks++;
    if (busy_cyc.size() != 10 || busy_cyc[0] != 1 || busy_cyc[busy_cyc.size()-1] != 10) begin
      n_fail++; $display("FAIL init_busy got %0d cycles exp cycles 1..10", busy_cyc.size());
    end
  endtask

  task automatic test_backpressure();
    drive_sweep(M_BP, 80, 1);
    for (int i = 0; i < D; i++) exp_q.push_back({AW'(i), 32'hA0 + i});
    n_checks++; if (hs_cyc.size() != D) begin n_fail++; $display("FAIL bp_hs_count got %0d exp %0d", hs_cyc.size(), D); end
    for (int i = 0; i < hs_cyc.size() && exp_q.size() > 0; i++) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if ({hs_addr[i], hs_data[i]} !== exp_e) begin
        n_fail++; $display("FAIL bp_out[%0d] got (%0d,%h) exp (%0d,%h)", i, hs_addr[i], hs_data[i], exp_e[W+AW-1:W], exp_e[W-1:0]);
      end
    end
    n_checks++; if (stall_err != 0) begin n_fail++; $display("FAIL bp_stall_stable got %0d changes exp 0", stall_err); end
    n_checks++;
    if (done_cyc.size() != 1 || hs_cyc.size() != D || done_cyc[0] != hs_cyc[D-1] + 1) begin
      n_fail++; $display("FAIL bp_done got %0d pulses first %0d exp 1 pulse after last handshake", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
  endtask

  task automatic test_deferred_start();
    int exp_ren[8];
    exp_ren = '{6, 7, 8, 12, 13, 14, 15, 16};
    drive_sweep(M_DEFER, 60, 1);
    for (int i = 0; i < D; i++) exp_q.push_back({AW'(i), 32'hA0 + i});
    n_checks++; if (ren_cyc.size() != D) begin n_fail++; $display("FAIL defer_ren_count got %0d exp %0d", ren_cyc.size(), D); end
    for (int i = 0; i < ren_cyc.size() && i < D; i++) begin
      n_checks++;
      if (ren_cyc[i] != exp_ren[i] || ren_addr[i] !== AW'(i)) begin
        n_fail++; $display("FAIL defer_ren[%0d] got cyc %0d addr %0d exp cyc %0d addr %0d", i, ren_cyc[i], ren_addr[i], exp_ren[i], i);
      end
    end
    n_checks++;
    if (busy_cyc.size() == 0 || busy_cyc[0] != 6) begin
      n_fail++; $display("FAIL defer_busy_start got %0d exp 6", (busy_cyc.size() > 0) ? busy_cyc[0] : -1);
    end
    n_checks++; if (hs_cyc.size() != D) begin n_fail++; $display("FAIL defer_hs_count got %0d exp %0d", hs_cyc.size(), D); end
    for (int i = 0; i < hs_cyc.size() && exp_q.size() > 0; i++) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if ({hs_addr[i], hs_data[i]} !== exp_e) begin
        n_fail++; $display("FAIL defer_out[%0d] got (%0d,%h) exp (%0d,%h)", i, hs_addr[i], hs_data[i], exp_e[W+AW-1:W], exp_e[W-1:0]);
      end
    end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL defer_done_count got %0d exp 1", done_cyc.size()); end
  endtask

  task automatic test_start_while_busy();
    drive_sweep(M_BUSYSTART, 40, 1);
    n_checks++; if (ren_cyc.size() != D) begin n_fail++; $display("FAIL busystart_ren_count got %0d exp %0d", ren_cyc.size(), D); end
    n_checks++; if (hs_cyc.size() != D) begin n_fail++; $display("FAIL busystart_hs_count got %0d exp %0d", hs_cyc.size(), D); end
    n_checks++;
    if (done_cyc.size() != 1 || done_cyc[0] != 11) begin
      n_fail++; $display("FAIL busystart_done got %0d pulses first %0d exp 1 pulse at 11", done_cyc.size(), (done_cyc.size() > 0) ? done_cyc[0] : -1);
    end
    n_checks++;
    if (busy_cyc.size() == 0 || busy_cyc[busy_cyc.size()-1] != 10 || BUSY !== 1'b0) begin
      n_fail++; $display("FAIL busystart_busy_end got last %0d now %b exp last 10 now 0", (busy_cyc.size() > 0) ? busy_cyc[busy_cyc.size()-1] : -1, BUSY);
    end
  endtask

  task automatic test_reset_mid_sweep();
    clear_logs();
    t0 = cyc;
    START = 1'b1; MEM_READY = 1'b1; OUT_RDY = 1'b0;
    step();
    START = 1'b0;
    repeat (3) step();
    n_checks++; if (OUT_VAL !== 1'b1 || BUSY !== 1'b1) begin n_fail++; $display("FAIL rst_pre_state got val %b busy %b exp 1 1", OUT_VAL, BUSY); end
    step();
    RST = 1'b1;
    #1;
    n_checks++; if (OUT_VAL !== 1'b0) begin n_fail++; $display("FAIL rst_mid_out_val got %b exp 0", OUT_VAL); end
    n_checks++; if (REN !== 1'b0)     begin n_fail++; $display("FAIL rst_mid_ren got %b exp 0", REN); end
    n_checks++; if (BUSY !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_busy got %b exp 0", BUSY); end
    n_checks++; if (DONE !== 1'b0)    begin n_fail++; $display("FAIL rst_mid_done got %b exp 0", DONE); end
    step();
    RST = 1'b0;
    OUT_RDY = 1'b1;
    step();
    drive_sweep(M_PLAIN, 40, 1);
    for (int i = 0; i < D; i++) exp_q.push_back({AW'(i), 32'hA0 + i});
    n_checks++;
    if (ren_addr.size() == 0 || ren_addr[0] !== '0 || ren_cyc[0] != 1) begin
      n_fail++; $display("FAIL rst_restart_first_read got addr %0d exp addr 0 at cycle 1", (ren_addr.size() > 0) ? int'(ren_addr[0]) : -1);
    end
    n_checks++; if (hs_cyc.size() != D) begin n_fail++; $display("FAIL rst_restart_hs_count got %0d exp %0d", hs_cyc.size(), D); end
    for (int i = 0; i < hs_cyc.size() && exp_q.size() > 0; i++) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if ({hs_addr[i], hs_data[i]} !== exp_e) begin
        n_fail++; $display("FAIL rst_restart_out[%0d] got (%0d,%h) exp (%0d,%h)", i, hs_addr[i], hs_data[i], exp_e[W+AW-1:W], exp_e[W-1:0]);
      end
    end
    n_checks++; if (done_cyc.size() != 1) begin n_fail++; $display("FAIL rst_restart_done got %0d exp 1", done_cyc.size()); end
  endtask

  task automatic test_back_to_back();
    drive_sweep(M_B2B, 60, 2);
    for (int i = 0; i < 2 * D; i++) exp_q.push_back({AW'(i % D), 32'hA0 + (i % D)});
    n_checks++;
    if (done_cyc.size() != 2 || done_cyc[0] != 11 || done_cyc[1] != 22) begin
      n_fail++; $display("FAIL b2b_done got %0d pulses exp 2 at cycles 11 and 22", done_cyc.size());
    end
    n_checks++;
    if (ren_cyc.size() != 2 * D || ren_cyc[D] != 12 || ren_addr[D] !== '0) begin
      n_fail++; $display("FAIL b2b_second_start got %0d reads exp 16 with read 8 at cycle 12 addr 0", ren_cyc.size());
    end
    n_checks++; if (hs_cyc.size() != 2 * D) begin n_fail++; $display("FAIL b2b_hs_count got %0d exp %0d", hs_cyc.size(), 2 * D); end
    for (int i = 0; i < hs_cyc.size() && exp_q.size() > 0; i++) begin
      exp_e = exp_q.pop_front();
      n_checks++;
      if ({hs_addr[i], hs_data[i]} !== exp_e) begin
        n_fail++; $display("FAIL b2b_out[%0d] got (%0d,%h) exp (%0d,%h)", i, hs_addr[i], hs_data[i], exp_e[W+AW-1:W], exp_e[W-1:0]);
      end
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    RST = 1'b1; START = 1'b0; MEM_READY = 1'b0; OUT_RDY = 1'b0;
    test_reset();
    test_init_sweep();
    test_backpressure();
    test_deferred_start();
    test_start_while_busy();
    test_reset_mid_sweep();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout got no completion exp finish before 200000");
    $fatal(1);
  end

endmodule
